// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/DM arbiter onto one single-ported synchronous memory; optional MEM_ARB_ROUND_ROBIN_EN
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int SEL_WIDTH   = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_en,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_read_data,
   output logic                  if_ready,
   input  logic                  dm_en,
   input  logic [SEL_WIDTH-1:0]  dm_write_en,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_write_data,
   output logic [DATA_WIDTH-1:0] dm_read_data,
   output logic                  dm_ready,
   output logic                  mem_en,
   output logic [SEL_WIDTH-1:0]  mem_write_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  stall
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   localparam logic       OWN_IF    = 1'b0;
   localparam logic       OWN_DM    = 1'b1;
   localparam logic [2:0] WAIT_LOAD = 3'(MEM_LATENCY - 1);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_latency
      $error("unified_mem_arbiter: MEM_LATENCY=%0d outside legal range 1..8", MEM_LATENCY);
   end

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  is_write_q, is_write_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  mem_en_q, mem_en_d;
   logic [SEL_WIDTH-1:0]  mem_write_en_q, mem_write_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
   logic                  if_ready_q, if_ready_d;
   logic                  dm_ready_q, dm_ready_d;
   logic [DATA_WIDTH-1:0] if_hold_q, if_hold_d;
   logic [DATA_WIDTH-1:0] dm_hold_q, dm_hold_d;
   logic                  grant_dm;
   logic                  resp_read;

   // Pick the port to serve when the FSM is idle; DM wins ties unless round-robin is built in
   always_comb begin
      grant_dm = dm_en;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (dm_en && if_en) begin
         grant_dm = (owner_q == OWN_IF);
      end
`endif
   end

   // Issue/wait/response sequencing and next values of every registered output
   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      is_write_d       = is_write_q;
      cnt_d            = cnt_q;
      mem_en_d         = 1'b0;
      mem_write_en_d   = '0;
      mem_addr_d       = mem_addr_q;
      mem_write_data_d = mem_write_data_q;
      if_ready_d       = 1'b0;
      dm_ready_d       = 1'b0;
      if_hold_d        = if_hold_q;
      dm_hold_d        = dm_hold_q;
      case (state_q)
         ST_IDLE: begin
            if (if_en || dm_en) begin
               owner_d    = grant_dm ? OWN_DM : OWN_IF;
               is_write_d = grant_dm && (dm_write_en != '0);
               mem_addr_d = grant_dm ? dm_addr : if_addr;
               if (grant_dm) begin
                  mem_write_data_d = dm_write_data;
                  mem_write_en_d   = dm_write_en;
               end
               mem_en_d = 1'b1;
               cnt_d    = WAIT_LOAD;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (MEM_LATENCY > 1) begin
               state_d = ST_WAIT;
            end else begin
               state_d    = ST_RESP;
               if_ready_d = (owner_q == OWN_IF);
               dm_ready_d = (owner_q == OWN_DM);
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d    = ST_RESP;
               if_ready_d = (owner_q == OWN_IF);
               dm_ready_d = (owner_q == OWN_DM);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!is_write_q) begin
               if (owner_q == OWN_IF) begin
                  if_hold_d = mem_read_data;
               end else begin
                  dm_hold_d = mem_read_data;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         owner_q          <= OWN_IF;
         is_write_q       <= 1'b0;
         cnt_q            <= 3'd0;
         mem_en_q         <= 1'b0;
         mem_write_en_q   <= '0;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
         if_ready_q       <= 1'b0;
         dm_ready_q       <= 1'b0;
         if_hold_q        <= '0;
         dm_hold_q        <= '0;
      end else begin
         state_q          <= state_d;
         owner_q          <= owner_d;
         is_write_q       <= is_write_d;
         cnt_q            <= cnt_d;
         mem_en_q         <= mem_en_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
         if_ready_q       <= if_ready_d;
         dm_ready_q       <= dm_ready_d;
         if_hold_q        <= if_hold_d;
         dm_hold_q        <= dm_hold_d;
      end
   end

   // Read data flows straight through in the response cycle, then comes from the hold register
   always_comb begin
      resp_read    = (state_q == ST_RESP) && !is_write_q;
      if_read_data = (resp_read && owner_q == OWN_IF) ? mem_read_data : if_hold_q;
      dm_read_data = (resp_read && owner_q == OWN_DM) ? mem_read_data : dm_hold_q;
   end

   assign if_ready       = if_ready_q;
   assign dm_ready       = dm_ready_q;
   assign mem_en         = mem_en_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_write_data_q;
   assign stall          = (if_en & ~if_ready_q) | (dm_en & ~dm_ready_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter at MEM_LATENCY 1 and 4
module tb_unified_mem_arbiter;

   localparam int LAT0 = 1;
   localparam int LAT1 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  if_en, dm_en, if_ready, dm_ready, mem_en, stall;
   logic [31:0] if_addr[2], dm_addr[2], dm_wdata[2], if_rdata[2], dm_rdata[2];
   logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
   logic [3:0]  dm_we[2], mem_we[2];

   int total = 0;
   int bad = 0;

   unified_mem_arbiter #(.MEM_LATENCY(LAT0)) dut0 (
      .clk(clk), .rst(rst),
      .if_en(if_en[0]), .if_addr(if_addr[0]), .if_read_data(if_rdata[0]), .if_ready(if_ready[0]),
      .dm_en(dm_en[0]), .dm_write_en(dm_we[0]), .dm_addr(dm_addr[0]), .dm_write_data(dm_wdata[0]),
      .dm_read_data(dm_rdata[0]), .dm_ready(dm_ready[0]),
      .mem_en(mem_en[0]), .mem_write_en(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_write_data(mem_wdata[0]), .mem_read_data(mem_rdata[0]), .stall(stall[0]));

   unified_mem_arbiter #(.MEM_LATENCY(LAT1)) dut1 (
      .clk(clk), .rst(rst),
      .if_en(if_en[1]), .if_addr(if_addr[1]), .if_read_data(if_rdata[1]), .if_ready(if_ready[1]),
      .dm_en(dm_en[1]), .dm_write_en(dm_we[1]), .dm_addr(dm_addr[1]), .dm_write_data(dm_wdata[1]),
      .dm_read_data(dm_rdata[1]), .dm_ready(dm_ready[1]),
      .mem_en(mem_en[1]), .mem_write_en(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_write_data(mem_wdata[1]), .mem_read_data(mem_rdata[1]), .stall(stall[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int idx);
      if (idx == 64) return 32'h3C010001;
      if (idx == 16) return 32'h11223344;
      return {16'(idx) ^ 16'h5A5A, ~16'(idx)};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   // memory macro fixture: fixed read latency, byte-enabled writes
   bit [31:0]   mem[2][256];
   bit          mem_wr[2][256];
   logic [31:0] pipe[2][8];

   function automatic logic [31:0] rd_word(input int k, input int idx);
      return mem_wr[k][idx] ? mem[k][idx] : init_word(idx);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 7; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
         pipe[k][0] <= mem_en[k] ? rd_word(k, int'(mem_addr[k][9:2])) : $urandom;
         if (mem_en[k] && mem_we[k] != 4'd0) begin
            mem[k][mem_addr[k][9:2]]    <= merge(rd_word(k, int'(mem_addr[k][9:2])), mem_wdata[k], mem_we[k]);
            mem_wr[k][mem_addr[k][9:2]] <= 1'b1;
         end
      end
   end
   assign mem_rdata[0] = pipe[0][LAT0-1];
   assign mem_rdata[1] = pipe[1][LAT1-1];

   // transaction-level reference: one grant per free slot, fixed timing offsets from the grant
   bit [31:0]   sm[2][256];
   bit          sm_wr[2][256];
   int          cyc = 0;
   int          free_at[2], issue_at[2], ready_at[2];
   bit          own_dm[2], is_wr[2], last_dm[2];
   logic [31:0] exp_rd[2], exp_addr[2], exp_wdata[2], hold_if[2], hold_dm[2];
   logic [3:0]  exp_we[2];

   function automatic logic [31:0] sm_read(input int k, input int idx);
      return sm_wr[k][idx] ? sm[k][idx] : init_word(idx);
   endfunction

   function automatic bit tie_to_dm(input bit prev_dm);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return !prev_dm;
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      bit e_if, e_dm, e_iss, g;
      int idx;
      logic [31:0] a;
      for (int k = 0; k < 2; k++) begin
         free_at[k] = 0; issue_at[k] = -1; ready_at[k] = -1;
         own_dm[k] = 0; is_wr[k] = 0; last_dm[k] = 0;
         hold_if[k] = 0; hold_dm[k] = 0; exp_rd[k] = 0; exp_addr[k] = 0; exp_wdata[k] = 0; exp_we[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               free_at[k] = cyc + 1; issue_at[k] = -1; ready_at[k] = -1;
               last_dm[k] = 0; hold_if[k] = 0; hold_dm[k] = 0;
               chk("rst_ctrl", {28'd0, mem_en[k], if_ready[k], dm_ready[k], |mem_we[k]}, 32'd0);
               chk("rst_mem_addr", mem_addr[k], 32'd0);
               chk("rst_if_rdata", if_rdata[k], 32'd0);
               chk("rst_dm_rdata", dm_rdata[k], 32'd0);
            end else begin
               e_if  = (cyc == ready_at[k]) && !own_dm[k];
               e_dm  = (cyc == ready_at[k]) && own_dm[k];
               e_iss = (cyc == issue_at[k]);
               if (e_if) hold_if[k] = exp_rd[k];
               if (e_dm && !is_wr[k]) hold_dm[k] = exp_rd[k];
               chk("if_ready", {31'd0, if_ready[k]}, {31'd0, e_if});
               chk("dm_ready", {31'd0, dm_ready[k]}, {31'd0, e_dm});
               chk("mem_en", {31'd0, mem_en[k]}, {31'd0, e_iss});
               chk("mem_write_en", {28'd0, mem_we[k]}, {28'd0, (e_iss && own_dm[k]) ? exp_we[k] : 4'd0});
               chk("if_read_data", if_rdata[k], hold_if[k]);
               chk("dm_read_data", dm_rdata[k], hold_dm[k]);
               chk("stall", {31'd0, stall[k]}, {31'd0, (if_en[k] & ~e_if) | (dm_en[k] & ~e_dm)});
               if (e_iss) chk("mem_addr", mem_addr[k], exp_addr[k]);
               if (e_iss && is_wr[k]) chk("mem_write_data", mem_wdata[k], exp_wdata[k]);
               if (cyc == free_at[k]) begin
                  if (if_en[k] || dm_en[k]) begin
                     g = dm_en[k] && (!if_en[k] || tie_to_dm(last_dm[k]));
                     own_dm[k] = g; last_dm[k] = g;
                     a = g ? dm_addr[k] : if_addr[k];
                     idx = int'(a[9:2]);
                     exp_addr[k] = a; exp_wdata[k] = dm_wdata[k];
                     exp_we[k] = g ? dm_we[k] : 4'd0;
                     is_wr[k] = g && (dm_we[k] != 4'd0);
                     if (is_wr[k]) begin
                        sm[k][idx] = merge(sm_read(k, idx), dm_wdata[k], dm_we[k]);
                        sm_wr[k][idx] = 1'b1;
                     end else begin
                        exp_rd[k] = sm_read(k, idx);
                     end
                     issue_at[k] = cyc + 1;
                     ready_at[k] = cyc + 1 + lat_of(k);
                     free_at[k]  = cyc + 2 + lat_of(k);
                  end else begin
                     free_at[k] = cyc + 1;
                  end
               end
            end
         end
         cyc++;
      end
   end

   // one request on one port of one instance; reports data and cycles from request to ready
   task automatic xact(input int k, input bit dm, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output int lat_seen);
      lat_seen = -1;
      rdata = 32'd0;
      if (dm) begin
         dm_en[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
      end else begin
         if_en[k] = 1'b1; if_addr[k] = addr;
      end
      for (int j = 0; j < 20 && lat_seen < 0; j++) begin
         @(negedge clk);
         if (dm ? dm_ready[k] : if_ready[k]) begin
            lat_seen = j;
            rdata = dm ? dm_rdata[k] : if_rdata[k];
         end
      end
      @(posedge clk); #1;
      if (dm) dm_en[k] = 1'b0; else if_en[k] = 1'b0;
   endtask

   typedef struct {
      int          k;
      bit          dm;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [31:0] rd;
      int lt, n_if, n_dm, n;
      int order[$];
      int exp_order[6];
      bit act_if[2], act_dm[2], rif[2], rdm[2];

      vt[0] = '{0, 1'b0, 4'h0, 32'h100, 32'h0,        32'h3C010001, 1 + LAT0};
      vt[1] = '{0, 1'b1, 4'h3, 32'h040, 32'hAABBCCDD, 32'h00000000, 1 + LAT0};
      vt[2] = '{0, 1'b1, 4'h0, 32'h040, 32'h0,        32'h1122CCDD, 1 + LAT0};
      vt[3] = '{0, 1'b1, 4'hC, 32'h040, 32'h55667788, 32'h1122CCDD, 1 + LAT0};
      vt[4] = '{0, 1'b1, 4'h0, 32'h040, 32'h0,        32'h5566CCDD, 1 + LAT0};
      vt[5] = '{0, 1'b0, 4'h0, 32'h040, 32'h0,        32'h5566CCDD, 1 + LAT0};
      vt[6] = '{1, 1'b1, 4'h0, 32'h008, 32'h0,        init_word(2), 1 + LAT1};
      vt[7] = '{1, 1'b0, 4'h0, 32'h100, 32'h0,        32'h3C010001, 1 + LAT1};
      vt[8] = '{0, 1'b1, 4'hF, 32'h044, 32'hDEADBEEF, 32'h5566CCDD, 1 + LAT0};
      vt[9] = '{0, 1'b0, 4'h0, 32'h044, 32'h0,        32'hDEADBEEF, 1 + LAT0};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{1, 0, 1, 0, 1, 0};
`else
      exp_order = '{1, 1, 1, 0, 0, 0};
`endif

      if_en = 2'b00; dm_en = 2'b00;
      for (int k = 0; k < 2; k++) begin
         if_addr[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0; dm_we[k] = 0;
         act_if[k] = 0; act_dm[k] = 0; rif[k] = 0; rdm[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         xact(vt[i].k, vt[i].dm, vt[i].we, vt[i].addr, vt[i].wdata, rd, lt);
         chk($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_latency", i), lt, vt[i].exp_lat);
      end

      // both ports held high on the L=1 instance; order of completions
      if_en[0] = 1'b1; if_addr[0] = 32'h100;
      dm_en[0] = 1'b1; dm_we[0] = 4'd0; dm_addr[0] = 32'h44;
      n_if = 0; n_dm = 0;
      for (int c = 0; c < 80 && (n_if < 3 || n_dm < 3); c++) begin
         @(negedge clk);
         if (dm_ready[0]) begin order.push_back(1); n_dm++; end
         if (if_ready[0]) begin order.push_back(0); n_if++; end
         @(posedge clk); #1;
         if (n_dm >= 3) dm_en[0] = 1'b0;
         if (n_if >= 3) if_en[0] = 1'b0;
      end
      if_en[0] = 1'b0; dm_en[0] = 1'b0;
      for (int i = 0; i < 6; i++)
         chk($sformatf("tie_order%0d", i), (i < order.size()) ? order[i] : 9, exp_order[i]);

      // reset while a DM read on the L=4 instance sits in its wait phase
      dm_en[1] = 1'b1; dm_we[1] = 4'd0; dm_addr[1] = 32'h8;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_ctrl", {28'd0, mem_en[1], dm_ready[1], if_ready[1], |mem_we[1]}, 32'd0);
      chk("async_rst_mem_addr", mem_addr[1], 32'd0);
      chk("async_rst_mem_wdata", mem_wdata[1], 32'd0);
      chk("async_rst_dm_rdata", dm_rdata[1], 32'd0);
      chk("async_rst_if_rdata", if_rdata[1], 32'd0);
      dm_en[1] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      xact(1, 1'b1, 4'd0, 32'h8, 32'd0, rd, lt);
      chk("post_rst_data", rd, init_word(2));
      chk("post_rst_latency", lt, 1 + LAT1);

      // fetch request withdrawn during the issue cycle still completes exactly once
      if_en[0] = 1'b1; if_addr[0] = 32'h40;
      @(posedge clk); #1;
      if_en[0] = 1'b0;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (if_ready[0]) n++;
      end
      chk("drop_ready_count", n, 1);
      @(posedge clk); #1;

      // random traffic on both instances, checked cycle by cycle by the reference
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin rif[k] = if_ready[k]; rdm[k] = dm_ready[k]; end
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            if (act_if[k] && rif[k]) begin act_if[k] = 0; if_en[k] = 1'b0; end
            if (act_dm[k] && rdm[k]) begin act_dm[k] = 0; dm_en[k] = 1'b0; end
            if (!act_if[k] && $urandom_range(0, 2) == 0) begin
               act_if[k] = 1; if_en[k] = 1'b1;
               if_addr[k] = {22'd0, 8'($urandom), 2'b00};
            end
            if (!act_dm[k] && $urandom_range(0, 2) == 0) begin
               act_dm[k] = 1; dm_en[k] = 1'b1;
               dm_addr[k] = {22'd0, 8'($urandom), 2'b00};
               dm_wdata[k] = $urandom;
               dm_we[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            end
         end
      end
      if_en = 2'b00; dm_en = 2'b00;
      repeat (15) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
